// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle shared by operand fetch, alu_pipe and writeback.
interface alu_pipe_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic [3:0]       alu_ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             cout;
    logic             overflow;

    modport master (output in_valid, src1, src2, alu_ctrl, out_ready,
                    input  in_ready, out_valid, result, zero, cout, overflow);
    modport slave  (input  in_valid, src1, src2, alu_ctrl, out_ready,
                    output in_ready, out_valid, result, zero, cout, overflow);
endinterface

// File: rtl/alu_pipe.sv
// Two-stage bit-slice ALU: stage 1 forms operands and propagate/generate terms,
// stage 2 resolves group-lookahead carries, selects the result and registers flags.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input logic     clk,
    input logic     rst,
    alu_pipe_if.slave bus
);
    localparam int NG = WIDTH / GROUP;

    logic             adv1;
    logic             adv2;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [NG-1:0]    bg;
    logic [NG-1:0]    bp;
    logic             acc_g;
    logic             acc_p;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_in1;
    logic [WIDTH-1:0] s1_in2;
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic [3:0]       s1_ctrl;
    logic [NG-1:0]    s1_bg;
    logic [NG-1:0]    s1_bp;

    logic [WIDTH:0]   c;
    logic             la_acc;
    logic             la_prop;
    logic [WIDTH-1:0] sum;
    logic             set_less;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cout;
    logic             alu_ovf;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             cout_q;
    logic             ovf_q;

    assign adv2         = !out_valid_q || bus.out_ready;
    assign adv1         = !s1_valid || adv2;
    assign bus.in_ready = adv1;

    // Operand conditioning plus per-block generate/propagate for the stage-2 carry chain.
    always_comb begin
        in1   = bus.alu_ctrl[3] ? ~bus.src1 : bus.src1;
        in2   = bus.alu_ctrl[2] ? ~bus.src2 : bus.src2;
        p     = in1 | in2;
        g     = in1 & in2;
        bg    = '0;
        bp    = '0;
        acc_g = 1'b0;
        acc_p = 1'b1;
        for (int b = 0; b < NG; b++) begin
            acc_g = 1'b0;
            acc_p = 1'b1;
            for (int i = 0; i < GROUP; i++) begin
                acc_g = g[b*GROUP+i] | (p[b*GROUP+i] & acc_g);
                acc_p = acc_p & p[b*GROUP+i];
            end
            bg[b] = acc_g;
            bp[b] = acc_p;
        end
    end

    // Block carries ripple between groups; bits inside a group use flat sum-of-products lookahead.
    always_comb begin
        c       = '0;
        c[0]    = s1_ctrl[2];
        la_acc  = 1'b0;
        la_prop = 1'b1;
        for (int b = 0; b < NG; b++) begin
            for (int i = 1; i < GROUP; i++) begin
                la_acc = 1'b0;
                for (int j = 0; j < i; j++) begin
                    la_prop = 1'b1;
                    for (int k = j + 1; k < i; k++) begin
                        la_prop = la_prop & s1_p[b*GROUP+k];
                    end
                    la_acc = la_acc | (s1_g[b*GROUP+j] & la_prop);
                end
                la_prop = 1'b1;
                for (int k = 0; k < i; k++) begin
                    la_prop = la_prop & s1_p[b*GROUP+k];
                end
                c[b*GROUP+i] = la_acc | (la_prop & c[b*GROUP]);
            end
            c[(b+1)*GROUP] = s1_bg[b] | (s1_bp[b] & c[b*GROUP]);
        end
    end

    always_comb begin
        sum      = s1_in1 ^ s1_in2 ^ c[WIDTH-1:0];
        set_less = sum[WIDTH-1] ^ c[WIDTH] ^ c[WIDTH-1];
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (s1_ctrl)
            4'b0000, 4'b1100: alu_res = s1_g;
            4'b0001, 4'b1101: alu_res = s1_p;
            4'b0010, 4'b0110: begin
                alu_res  = sum;
                alu_cout = c[WIDTH];
                alu_ovf  = c[WIDTH] ^ c[WIDTH-1];
            end
            4'b0111: begin
                alu_res[0] = set_less;
                alu_cout   = c[WIDTH];
            end
            default: ;
        endcase
    end

    // A stage only loads when its downstream neighbour can take what it holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_in1  <= in1;
                    s1_in2  <= in2;
                    s1_p    <= p;
                    s1_g    <= g;
                    s1_ctrl <= bus.alu_ctrl;
                    s1_bg   <= bg;
                    s1_bp   <= bp;
                end
            end
            if (adv2) begin
                out_valid_q <= s1_valid;
                if (s1_valid) begin
                    result_q <= alu_res;
                    zero_q   <= (alu_res == '0);
                    cout_q   <= alu_cout;
                    ovf_q    <= alu_ovf;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed literal cases, backpressure, reset, then
// randomized traffic compared every cycle against an arithmetic reference model.
module tb_alu_pipe;
    localparam int WIDTH = 32;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic             z;
        logic             c;
        logic             o;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   outputs_seen = 0;
    int   base_seen;
    exp_t exp_q[$];
    logic held_valid = 1'b0;
    exp_t held;

    alu_pipe_if #(.WIDTH(WIDTH)) bus ();

    alu_pipe #(.WIDTH(WIDTH), .GROUP(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic checkWord(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%h required=0x%h", name, act, req);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    // Reference model straight from the operation table, using wide integer arithmetic.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [3:0] ctrl);
        exp_t          e;
        logic [WIDTH:0] wide;
        e    = '0;
        wide = '0;
        case (ctrl)
            4'b0000: e.r = a & b;
            4'b0001: e.r = a | b;
            4'b0010: begin
                wide = {1'b0, a} + {1'b0, b};
                e.r  = wide[WIDTH-1:0];
                e.c  = wide[WIDTH];
                e.o  = (a[WIDTH-1] == b[WIDTH-1]) && (e.r[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0110: begin
                wide = {1'b0, a} + {1'b0, ~b} + 33'd1;
                e.r  = wide[WIDTH-1:0];
                e.c  = wide[WIDTH];
                e.o  = (a[WIDTH-1] != b[WIDTH-1]) && (e.r[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0111: begin
                wide = {1'b0, a} + {1'b0, ~b} + 33'd1;
                e.c  = wide[WIDTH];
                e.r  = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            end
            4'b1100: e.r = ~(a | b);
            4'b1101: e.r = ~(a & b);
            default: ;
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    // Compare process: in-flight bundles are queued at the input transfer and retired at the output transfer.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            held_valid = 1'b0;
        end else begin
            checkBit("mon_in_ready", bus.in_ready, !(exp_q.size() == 2 && !bus.out_ready));
            if (exp_q.size() != 1)
                checkBit("mon_out_valid", bus.out_valid, exp_q.size() == 2);
            if (held_valid) begin
                checkBit("mon_hold_valid", bus.out_valid, 1'b1);
                checkWord("mon_hold_result", bus.result, held.r);
                checkBit("mon_hold_zero", bus.zero, held.z);
                checkBit("mon_hold_cout", bus.cout, held.c);
                checkBit("mon_hold_ovf", bus.overflow, held.o);
            end
            if (bus.out_valid && exp_q.size() > 0) begin
                checkWord("mon_result", bus.result, exp_q[0].r);
                checkBit("mon_zero", bus.zero, exp_q[0].z);
                checkBit("mon_cout", bus.cout, exp_q[0].c);
                checkBit("mon_ovf", bus.overflow, exp_q[0].o);
            end
            held_valid = bus.out_valid && !bus.out_ready;
            held.r = bus.result;
            held.z = bus.zero;
            held.c = bus.cout;
            held.o = bus.overflow;
            if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                outputs_seen++;
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.src1, bus.src2, bus.alu_ctrl));
        end
    end

    // Presents a bundle at posedge+1 and returns at posedge+1 after the edge that accepted it.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [3:0] ctrl);
        bit accepted;
        accepted     = 1'b0;
        bus.in_valid = 1'b1;
        bus.src1     = a;
        bus.src2     = b;
        bus.alu_ctrl = ctrl;
        for (int n = 0; n < 100 && !accepted; n++) begin
            @(negedge clk);
            accepted = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!accepted) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout actual=in_ready_low required=in_ready_high");
        end
    endtask

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [3:0] ctrl, input logic [WIDTH-1:0] er,
                               input logic ez, input logic ec, input logic eo);
        exp_t m;
        m = model(a, b, ctrl);
        checkWord({name, "_model_result"}, m.r, er);
        checkBit({name, "_model_flags_z"}, m.z, ez);
        checkBit({name, "_model_flags_c"}, m.c, ec);
        checkBit({name, "_model_flags_o"}, m.o, eo);
        checkWord({name, "_result"}, bus.result, er);
        checkBit({name, "_zero"}, bus.zero, ez);
        checkBit({name, "_cout"}, bus.cout, ec);
        checkBit({name, "_overflow"}, bus.overflow, eo);
    endtask

    // Single bundle into an empty pipe: registered at the accept edge, result registered one edge later.
    task automatic runDirected(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [3:0] ctrl, input logic [WIDTH-1:0] er,
                               input logic ez, input logic ec, input logic eo);
        applyStimulus(a, b, ctrl);
        bus.in_valid = 1'b0;
        checkBit({name, "_valid_stage1"}, bus.out_valid, 1'b0);
        @(posedge clk);
        #1;
        checkBit({name, "_valid_stage2"}, bus.out_valid, 1'b1);
        checkOutput(name, a, b, ctrl, er, ez, ec, eo);
        @(posedge clk);
        #1;
        checkBit({name, "_valid_drained"}, bus.out_valid, 1'b0);
    endtask

    function automatic logic [WIDTH-1:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 7));
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [3:0] rnd_ctrl();
        case ($urandom_range(0, 7))
            0: return 4'b0000;
            1: return 4'b0001;
            2: return 4'b0010;
            3: return 4'b0110;
            4: return 4'b0111;
            5: return 4'b1100;
            6: return 4'b1101;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        bus.in_valid  = 1'b0;
        bus.src1      = '0;
        bus.src2      = '0;
        bus.alu_ctrl  = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkBit("reset_out_valid", bus.out_valid, 1'b0);
        checkBit("reset_in_ready", bus.in_ready, 1'b1);
        checkWord("reset_result", bus.result, 32'h0);
        checkBit("reset_zero", bus.zero, 1'b0);
        checkBit("reset_cout", bus.cout, 1'b0);
        checkBit("reset_ovf", bus.overflow, 1'b0);

        runDirected("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        runDirected("sub_eq", 32'd5, 32'd5, 4'b0110, 32'h0, 1'b1, 1'b1, 1'b0);
        runDirected("slt_neg", 32'h8000_0000, 32'h0000_0001, 4'b0111, 32'h1, 1'b0, 1'b1, 1'b0);
        runDirected("slt_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'b0111, 32'h0, 1'b1, 1'b0, 1'b0);
        runDirected("nor", 32'hF0F0_F0F0, 32'h0F0F_0F00, 4'b1100, 32'h0000_000F, 1'b0, 1'b0, 1'b0);
        runDirected("nand", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1101, 32'h0, 1'b1, 1'b0, 1'b0);
        runDirected("and", 32'hFF00_FF00, 32'h0FF0_0FF0, 4'b0000, 32'h0F00_0F00, 1'b0, 1'b0, 1'b0);
        runDirected("or", 32'hFF00_FF00, 32'h0FF0_0FF0, 4'b0001, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
        runDirected("illegal", 32'h1234_5678, 32'h9ABC_DEF0, 4'b1111, 32'h0, 1'b1, 1'b0, 1'b0);

        // Backpressure: the sink stalls after the first acceptance, so the pipe fills with two bundles.
        base_seen = outputs_seen;
        applyStimulus(32'd1, 32'd1, 4'b0010);
        bus.out_ready = 1'b0;
        applyStimulus(32'd10, 32'd20, 4'b0010);
        bus.src1 = 32'd100;
        bus.src2 = 32'd200;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checkBit("bp_in_ready_low", bus.in_ready, 1'b0);
            checkWord("bp_hold_first", bus.result, 32'd2);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        applyStimulus(32'd100, 32'd200, 4'b0010);
        applyStimulus(32'hFFFF_FFFF, 32'd1, 4'b0010);
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkWord("bp_output_count", 32'(outputs_seen - base_seen), 32'd4);

        // Reset with two bundles in flight and a third being offered on the reset edge.
        applyStimulus(32'd7, 32'd8, 4'b0010);
        applyStimulus(32'd9, 32'd9, 4'b0110);
        bus.src1 = 32'd55;
        bus.src2 = 32'd66;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        checkBit("rst_mid_out_valid", bus.out_valid, 1'b0);
        checkWord("rst_mid_result", bus.result, 32'h0);
        checkBit("rst_mid_in_ready", bus.in_ready, 1'b1);
        runDirected("post_rst_add", 32'd1, 32'd2, 4'b0010, 32'd3, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with random sink stalls; the compare process does all checking.
        for (int n = 0; n < 600; n++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.src1      = rnd_operand();
            bus.src2      = rnd_operand();
            bus.alu_ctrl  = rnd_ctrl();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        checkBit("drain_empty", exp_q.size() == 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
